// File: rtl/wave_table_initializer.sv
// Waveform table generator: writes sine/triangle/sawtooth/square samples into per-channel
// table RAMs over a valid/ready port; fills every channel with sine after reset.
module wave_table_initializer #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   ch,
  output logic              wr_v,
  input  logic              wr_ready,
  output logic [CH_W-1:0]   wr_ch,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] ready_ch
);

  localparam int unsigned PW = DATA_W + 2 * ADDR_W + 4;
  localparam logic [PW-1:0] MID   = PW'(1) << (DATA_W - 1);
  localparam logic [PW-1:0] AMP   = MID - PW'(1);
  localparam logic [PW-1:0] HALF  = PW'(1) << (ADDR_W - 1);
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;
  localparam logic [PW-1:0] FULL  = (PW'(1) << DATA_W) - PW'(1);

  typedef enum logic [1:0] {S_AUTO, S_IDLE, S_CALC, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                auto_q, auto_d;
  logic                wr_v_d, busy_d, done_d;
  logic [CH_W-1:0]     wr_ch_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [NUM_CH-1:0]   ready_d;

  logic [PW-1:0]       a_w, h_w, tri_x, sine_q, tri_f, saw_v;
  logic [DATA_W-1:0]   sample_c;

  // Sample for the current address; the top address bit selects the half-period
  always_comb begin
    a_w    = PW'(addr_q);
    h_w    = PW'(addr_q[ADDR_W-2:0]);
    sine_q = (PW'(16) * AMP * h_w * (HALF - h_w)) >> (2 * ADDR_W);
    tri_x  = a_w;
    case (addr_q[ADDR_W-1:ADDR_W-2])
      2'b00:   tri_x = a_w;
      2'b01:   tri_x = HALF - a_w;
      2'b10:   tri_x = a_w - HALF;
      default: tri_x = DEPTH - a_w;
    endcase
    tri_f  = (PW'(4) * AMP * tri_x) >> ADDR_W;
    saw_v  = (a_w * FULL) >> ADDR_W;
    case (mode_q)
      2'd0:    sample_c = addr_q[ADDR_W-1] ? DATA_W'(MID - sine_q) : DATA_W'(MID + sine_q);
      2'd1:    sample_c = addr_q[ADDR_W-1] ? DATA_W'(MID - tri_f)  : DATA_W'(MID + tri_f);
      2'd2:    sample_c = DATA_W'(saw_v);
      default: sample_c = addr_q[ADDR_W-1] ? DATA_W'(MID - AMP)    : DATA_W'(MID + AMP);
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    ch_d      = ch_q;
    auto_d    = auto_q;
    wr_ch_d   = wr_ch;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    ready_d   = ready_ch;
    done_d    = 1'b0;
    case (state_q)
      S_AUTO: begin
        mode_d  = 2'd0;
        addr_d  = '0;
        auto_d  = 1'b1;
        state_d = S_CALC;
      end
      S_IDLE: begin
        if (start && (32'(ch) < NUM_CH)) begin
          mode_d      = mode;
          ch_d        = ch;
          auto_d      = 1'b0;
          ready_d[ch] = 1'b0;
          addr_d      = '0;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        wr_ch_d   = ch_q;
        wr_addr_d = addr_q;
        wr_data_d = sample_c;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (!(&addr_q)) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_CALC;
          end else begin
            ready_d[ch_q] = 1'b1;
            // The power-up fill walks through all channels before going idle
            if (auto_q && (32'(ch_q) < NUM_CH - 1)) begin
              ch_d    = ch_q + CH_W'(1);
              state_d = S_AUTO;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_v_d = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_AUTO;
      addr_q   <= '0;
      mode_q   <= 2'd0;
      ch_q     <= '0;
      auto_q   <= 1'b0;
      wr_v     <= 1'b0;
      wr_ch    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready_ch <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      ch_q     <= ch_d;
      auto_q   <= auto_d;
      wr_v     <= wr_v_d;
      wr_ch    <= wr_ch_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      ready_ch <= ready_d;
    end
  end

endmodule

// File: tb/tb_wave_table_initializer.sv
// Bench for wave_table_initializer: default instance under random backpressure and commands,
// plus a DATA_W=12/ADDR_W=10/NUM_CH=4 instance doing its power-up fill.
module tb_wave_table_initializer;

  localparam int unsigned DW = 9, AW = 8, NC = 2, CW = 1, N = 256;
  localparam int unsigned DW2 = 12, AW2 = 10, NC2 = 4, CW2 = 2, N2 = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, wr_ready, wr_v, busy, done;
  logic [1:0]    mode;
  logic [CW-1:0] ch, wr_ch;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NC-1:0] ready_ch;

  logic           rst2_n, wr_v2, busy2, done2;
  logic [CW2-1:0] wr_ch2;
  logic [AW2-1:0] wr_addr2;
  logic [DW2-1:0] wr_data2;
  logic [NC2-1:0] ready_ch2;

  wave_table_initializer #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ch(ch),
    .wr_v(wr_v), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .ready_ch(ready_ch));

  wave_table_initializer #(.DATA_W(DW2), .ADDR_W(AW2), .NUM_CH(NC2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(1'b0), .mode(2'd0), .ch(2'd0),
    .wr_v(wr_v2), .wr_ready(1'b1), .wr_ch(wr_ch2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .busy(busy2), .done(done2), .ready_ch(ready_ch2));

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference sample straight from the waveform formulas
  function automatic longint model(int dw, int aw, int md, int a);
    longint mid, amp, n, h, q4, x, v;
    mid = 64'(1) << (dw - 1);
    amp = mid - 1;
    n   = 64'(1) << aw;
    h   = n / 2;
    q4  = n / 4;
    case (md)
      0: begin
        x = a % h;
        v = (16 * amp * x * (h - x)) >> (2 * aw);
        return (a < h) ? mid + v : mid - v;
      end
      1: begin
        if (a < q4)          x = a;
        else if (a < h)      x = h - a;
        else if (a < 3 * q4) x = a - h;
        else                 x = n - a;
        v = (4 * amp * x) >> aw;
        return (a < h) ? mid + v : mid - v;
      end
      2: return (a * ((64'(1) << dw) - 1)) >> aw;
      default: return (a < h) ? mid + amp : mid - amp;
    endcase
  endfunction

  typedef struct {
    int ch;
    int addr;
    int data;
    int mode;
    bit last_ch;
    bit last_run;
  } wr_t;

  wr_t q[$];
  bit  m_valid = 1'b0, m_wv = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_idle = 1'b0, m_rst = 1'b0;
  logic [NC-1:0] m_ready = '0;
  int  m_cnt = 0;
  bit  rand_rdy = 1'b0;

  function automatic void push_run(int c, int md, bit last_run);
    for (int a = 0; a < int'(N); a++) begin
      wr_t e;
      e.ch = c; e.addr = a; e.mode = md;
      e.data = int'(model(DW, AW, md, a));
      e.last_ch = (a == int'(N) - 1);
      e.last_run = last_run && (a == int'(N) - 1);
      q.push_back(e);
    end
  endfunction

  // Compare current outputs with the model, then advance the model across the next edge
  always @(negedge clk) begin
    wr_t e;
    if (m_valid) begin
      check("wr_v", longint'(wr_v), longint'(m_wv));
      check("busy", longint'(busy), longint'(m_busy));
      check("done", longint'(done), longint'(m_done));
      check("ready_ch", longint'(ready_ch), longint'(m_ready));
      if (m_rst) begin
        check("rst_wr_ch", longint'(wr_ch), 64'd0);
        check("rst_wr_addr", longint'(wr_addr), 64'd0);
        check("rst_wr_data", longint'(wr_data), 64'd0);
      end
      if (m_wv) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: ch %0d addr %0d, none required", wr_ch, wr_addr);
        end else begin
          check("wr_ch", longint'(wr_ch), longint'(q[0].ch));
          check("wr_addr", longint'(wr_addr), longint'(q[0].addr));
          check("wr_data", longint'(wr_data), longint'(q[0].data));
        end
      end
    end
    m_rst = 1'b0;
    if (!rst_n) begin
      q.delete();
      for (int c = 0; c < int'(NC); c++) push_run(c, 0, c == int'(NC) - 1);
      m_ready = '0; m_idle = 1'b0; m_wv = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_cnt = 2; m_rst = 1'b1; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_wv && wr_ready && q.size() > 0) begin
        e = q.pop_front();
        if (e.mode == 0 && e.addr == 32)  check("lit_sine_a32", longint'(wr_data), 64'h1BF);
        if (e.mode == 0 && e.addr == 64)  check("lit_sine_a64", longint'(wr_data), 64'h1FF);
        if (e.mode == 1 && e.addr == 192) check("lit_tri_a192", longint'(wr_data), 64'h001);
        if (e.mode == 2 && e.addr == 255) check("lit_saw_a255", longint'(wr_data), 64'h1FD);
        if (e.mode == 3 && e.addr == 128) check("lit_sq_a128", longint'(wr_data), 64'h001);
        m_wv = 1'b0;
        if (e.last_ch) m_ready[e.ch] = 1'b1;
        if (e.last_run) begin
          m_idle = 1'b1;
          m_done = 1'b1;
        end else begin
          m_cnt = e.last_ch ? 2 : 1;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_wv = 1'b1;
      end else if (m_idle && start && int'(ch) < int'(NC)) begin
        push_run(int'(ch), int'(mode), 1'b1);
        m_ready[ch] = 1'b0;
        m_idle = 1'b0;
        m_cnt = 1;
      end
      m_busy = !m_idle;
    end
  end

  always @(posedge clk) begin
    #1 wr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Second instance: power-up sine fill of four 1024-entry tables with no backpressure
  int e2_ch = 0, e2_addr = 0, n2 = 0;
  bit d2_seen = 1'b0;
  always @(negedge clk) begin
    if (rst2_n) begin
      if (wr_v2) begin
        check("dut2_ch", longint'(wr_ch2), longint'(e2_ch));
        check("dut2_addr", longint'(wr_addr2), longint'(e2_addr));
        check("dut2_data", longint'(wr_data2), model(DW2, AW2, 0, e2_addr));
        if (e2_ch == 0 && e2_addr == 256) check("dut2_peak", longint'(wr_data2), 64'hFFF);
        n2++;
        e2_addr++;
        if (e2_addr == int'(N2)) begin
          e2_addr = 0;
          e2_ch++;
        end
      end
      if (done2) d2_seen = 1'b1;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!m_idle && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!m_idle) begin
      errors++;
      $display("FAIL %s: run not finished after %0d cycles", name, budget);
    end
  endtask

  int run_mode[4] = '{1, 2, 3, 0};
  int run_ch[4]   = '{1, 0, 1, 0};
  bit run_rnd[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int n;
    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; mode = 2'd0; ch = '0; wr_ready = 1'b1;

    check("pin_sine_a0",   model(DW, AW, 0, 0),   64'h100);
    check("pin_sine_a32",  model(DW, AW, 0, 32),  64'h1BF);
    check("pin_sine_a64",  model(DW, AW, 0, 64),  64'h1FF);
    check("pin_sine_a192", model(DW, AW, 0, 192), 64'h001);
    check("pin_tri_a0",    model(DW, AW, 1, 0),   64'h100);
    check("pin_tri_a64",   model(DW, AW, 1, 64),  64'h1FF);
    check("pin_tri_a128",  model(DW, AW, 1, 128), 64'h100);
    check("pin_tri_a192",  model(DW, AW, 1, 192), 64'h001);
    check("pin_saw_a255",  model(DW, AW, 2, 255), 64'h1FD);
    check("pin_sq_a127",   model(DW, AW, 3, 127), 64'h1FF);
    check("pin_sq_a128",   model(DW, AW, 3, 128), 64'h001);
    check("pin_sine12_a256", model(DW2, AW2, 0, 256), 64'hFFF);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rst2_n = 1'b1;
    wait_idle(3000, "auto_fill");

    for (int r = 0; r < 4; r++) begin
      rand_rdy = run_rnd[r];
      repeat (3) @(posedge clk);
      #1 start = 1'b1; mode = 2'(run_mode[r]); ch = CW'(run_ch[r]);
      @(posedge clk); #1 start = 1'b0; mode = 2'($urandom); ch = CW'($urandom);
      // Requests while a run is active must be ignored
      for (int s = 0; s < 5; s++) begin
        repeat (20 + int'($urandom_range(0, 30))) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_idle(4000, "cmd_run");
    end

    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; mode = 2'd2; ch = CW'(1);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(m_wv && q.size() > 0 && q[0].addr == 100) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_a100", longint'(n < 1000), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle(3000, "auto_after_reset");

    n = 0;
    while (!d2_seen && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut2_done", longint'(d2_seen), 64'd1);
    check("dut2_writes", longint'(n2), 64'd4096);
    check("dut2_ready", longint'(ready_ch2), 64'hF);
    check("dut2_busy", longint'(busy2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
